axi_wr_dispatch: RTL and testbench
==================================

// Module: axi_wr_dispatch
// PURPOSE
//  Parametrised AXI4 write-slave front end that accepts bursts and steers each W beat to one of
//  NUM_CH input FIFOs (ch0 = varint, ch1 = raw data, further channels reserved).
//  Successor to the single-beat, two-channel write FSM. Adds INCR/FIXED bursts, a per-beat push,
//  full-driven W backpressure, BRESP error reporting and per-channel clear.
//  Sits between the HPS AXI interconnect and the decoder datapath FIFOs.
// PARAMETERS
//  DATA_W  32  W data width, 32 or 64; strobe width is DATA_W/8
//  ID_W    4   AXI ID width
//  NUM_CH  2   number of downstream channels, 1..16
//  IDX_W   10  record-index counter width
// PORTS
//  clk          in   1           clock
//  reset        in   1           reset, synchronous, active-high
//  awid/awaddr  in   ID_W/32     AW channel, captured on handshake
//  awlen/awsize in   8/3         beats-1; beat size, must equal log2(DATA_W/8)
//  awburst      in   2           INCR or FIXED; WRAP is treated as an error
//  awvalid/awready  in/out  1    AW handshake
//  wdata/wstrb  in   DATA_W/DATA_W/8  W payload
//  wlast/wvalid in   1           W channel
//  wready       out  1           W handshake
//  bid/bresp    out  ID_W/2      write response
//  bvalid/bready    out/in  1    B handshake
//  ch_full      in   NUM_CH      per-channel FIFO full
//  ch_clr       out  NUM_CH      per-channel clear pulse
//  ch_push      out  NUM_CH      one-hot push, one per accepted beat
//  ch_data      out  DATA_W      = wdata; ch_strb = wstrb (out DATA_W/8)
//  ch_index     out  IDX_W       record index that travels with each push
// BEHAVIOUR
//  Addr decode: awaddr[7:4] = channel sel; awaddr[3:0] = mode: 0 NORMAL, 1 LAST (ends record).
//  Decode error (SLVERR): sel>=NUM_CH, mode>1, awsize illegal or awburst==WRAP.
//  FSM states: INIT, IDLE, DATA, DRAIN, RESP.
//  INIT: 1 cycle. ch_clr all ones, index<=0; then IDLE.
//  IDLE: awready=1. On awvalid, capture id/sel/mode/awlen into beat_cnt.
//    Go to DATA if the decode is legal, else to DRAIN with err=1.
//  DATA: wready = ~ch_full[sel]. Beat accepted when wvalid&wready.
//    Same cycle: ch_push[sel]=1, ch_data=wdata, ch_strb=wstrb, ch_index=index (zero latency).
//    beat_cnt decrements per accepted beat; on the beat with beat_cnt==0, go to RESP.
//    If mode==LAST, index increments on that final beat; 2**IDX_W-1 wraps to 0.
//    ch_index shows the pre-increment value. A full FIFO stalls W indefinitely; no timeout.
//  DRAIN: wready=1. Beats are discarded with no push and index unchanged. Exit to RESP on the beat_cnt==0 beat.
//  RESP: bvalid=1, bid=captured id, bresp = err ? 2'b10 : 2'b00. Stay until bready, then IDLE.
//    bvalid&bready in the first RESP cycle is legal: RESP lasts 1 cycle.
//  awready is only high in IDLE, so a new AW is never accepted before B completes.
//  Reset values: awready, wready, bvalid = 0; bid=0; bresp=0; ch_push=0; index=0.
//  Reset mid-burst: the burst is abandoned with no B. Next cycle is INIT (ch_clr pulse).
//  wlast is ignored for sequencing; beat_cnt is authoritative.
// CONFIGURATION
//  AXI_WR_DISPATCH_WLAST_CHECK_EN defined:
//    wlast != (beat_cnt==0) on any accepted beat sets err, giving SLVERR.
//    Beats are still pushed and the burst still ends by beat_cnt.
//  Undefined: wlast is unused and bresp depends on the decode result only.
// STRUCTURE
//  Package axi_wr_dispatch_pkg holds:
//    state localparams for INIT..RESP (one-hot);
//    BRESP_OKAY=2'b00, BRESP_SLVERR=2'b10;
//    BURST_FIXED/INCR/WRAP encodings;
//    address field constants SEL_LSB=4, SEL_MSB=7, MODE_MSB=3.
//  Sub-module axi_wr_dispatch_decode is combinational.
//    In: awaddr, awsize, awburst. Out: sel, mode, err.
//  The FSM, beat counter and index counter stay in the top module.
// TESTING
//  Reset, then 1 cycle -> ch_clr=all ones for 1 cycle; then awready=1, index=0.
//  AW 0x00, awlen=3, 4 beats -> 4 ch_push[0] pulses, ch_index=0 each, bresp=OKAY, bid matches.
//  AW 0xF1 with NUM_CH=16, awlen=0 -> one push on ch15 with index=0; index becomes 1.
//  Next AW 0xF1 -> push with index=1.
//  ch_full[0]=1 for 5 cycles mid-burst -> wready=0 those cycles; no push lost or duplicated.
//  AW 0x32 (mode=2), awlen=1 -> 2 beats drained, no push, bresp=SLVERR.
//  Index preset 1023, LAST write -> index wraps to 0.
//  Reset asserted mid-burst -> no bvalid, INIT clear pulse follows.
//  WLAST_CHECK_EN: wlast on beat 2 of 4 -> SLVERR, 4 pushes still occur.

Source files
------------

// File: rtl/axi_wr_dispatch_pkg.sv
// axi_wr_dispatch_pkg
//   Shared constants for the AXI write dispatcher: FSM state encodings
//   (one-hot), BRESP codes, AWBURST encodings, address field positions,
//   write modes and the legal AWSIZE for a given data width.
//   No ports.
package axi_wr_dispatch_pkg;

    // FSM states, one-hot
    localparam logic [4:0] ST_INIT  = 5'b00001;
    localparam logic [4:0] ST_IDLE  = 5'b00010;
    localparam logic [4:0] ST_DATA  = 5'b00100;
    localparam logic [4:0] ST_DRAIN = 5'b01000;
    localparam logic [4:0] ST_RESP  = 5'b10000;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // awaddr[SEL_MSB:SEL_LSB] selects the channel, awaddr[MODE_MSB:0] the mode
    localparam int SEL_LSB  = 4;
    localparam int SEL_MSB  = 7;
    localparam int MODE_MSB = 3;

    localparam logic [3:0] MODE_NORMAL = 4'd0;
    localparam logic [3:0] MODE_LAST   = 4'd1;

    // Only full-width beats are supported: AWSIZE = log2(bytes per beat)
    function automatic logic [2:0] legal_awsize(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_wr_dispatch_if.sv
// axi_wr_dispatch_if
//   AXI4 write-address / write-data / write-response signal bundle.
//   Parameters: DATA_W (32 or 64), ID_W.
//   Modports:
//     master - drives AW/W payload and valids, bready; sees readys and B
//     slave  - the dispatcher side, mirror of master
interface axi_wr_dispatch_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_wr_dispatch_decode.sv
// axi_wr_dispatch_decode
//   Combinational AW decode: splits awaddr into channel select and mode and
//   flags any request the dispatcher cannot serve.
//   Ports:
//     awaddr_i  in  32  write address (only [7:0] is meaningful)
//     awsize_i  in  3   beat size
//     awburst_i in  2   burst type
//     sel_o     out 4   channel select
//     mode_o    out 4   write mode (NORMAL / LAST)
//     err_o     out 1   request is illegal and must be drained with SLVERR
module axi_wr_dispatch_decode
    import axi_wr_dispatch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
) (
    input  logic [31:0] awaddr_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    output logic [3:0]  sel_o,
    output logic [3:0]  mode_o,
    output logic        err_o
);
    localparam logic [2:0] SIZE_LEGAL = legal_awsize(DATA_W);

    logic sel_err;
    logic unused_addr_hi;

    assign sel_o          = awaddr_i[SEL_MSB:SEL_LSB];
    assign mode_o         = awaddr_i[MODE_MSB:0];
    assign unused_addr_hi = ^awaddr_i[31:SEL_MSB+1];

    // With 16 channels every 4-bit select is valid
    generate
        if (NUM_CH < 16) begin : g_sel_chk
            assign sel_err = (sel_o >= 4'(NUM_CH));
        end else begin : g_sel_all
            assign sel_err = 1'b0;
        end
    endgenerate

    assign err_o = sel_err
                 | (mode_o > MODE_LAST)
                 | (awsize_i != SIZE_LEGAL)
                 | (awburst_i == BURST_WRAP);
endmodule

// File: rtl/axi_wr_dispatch.sv
// axi_wr_dispatch
//   AXI4 write-slave front end. Accepts one INCR/FIXED burst at a time and
//   pushes each W beat, with zero latency, into the selected channel FIFO
//   together with the current record index. Illegal requests are drained
//   and answered with SLVERR.
//   Parameters: DATA_W (32/64), ID_W, NUM_CH (1..16), IDX_W.
//   Ports:
//     clk, reset     clock; synchronous active-high reset
//     axi            write channels (slave modport)
//     ch_full_i      per-channel FIFO full, stalls W on the selected channel
//     ch_clr_o       per-channel clear, pulsed in INIT
//     ch_push_o      one-hot push per accepted beat
//     ch_data_o      beat data (= wdata)
//     ch_strb_o      beat strobes (= wstrb)
//     ch_index_o     record index travelling with each push
//   Build option: AXI_WR_DISPATCH_WLAST_CHECK_EN flags a wlast that disagrees
//   with the beat counter as SLVERR; the burst still ends on the count.
//
//   state | meaning
//   INIT  | one cycle after reset: clear all channels, index <= 0
//   IDLE  | awready high, waiting for an address
//   DATA  | legal burst, pushing beats to the selected channel
//   DRAIN | illegal burst, accepting and discarding beats
//   RESP  | bvalid high until bready
module axi_wr_dispatch
    import axi_wr_dispatch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 10
) (
    input  logic                clk,
    input  logic                reset,
    axi_wr_dispatch_if.slave    axi,
    input  logic [NUM_CH-1:0]   ch_full_i,
    output logic [NUM_CH-1:0]   ch_clr_o,
    output logic [NUM_CH-1:0]   ch_push_o,
    output logic [DATA_W-1:0]   ch_data_o,
    output logic [DATA_W/8-1:0] ch_strb_o,
    output logic [IDX_W-1:0]    ch_index_o
);
    logic [4:0]       state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [3:0]       sel_q, sel_d;
    logic [3:0]       mode_q, mode_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [3:0] dec_sel;
    logic [3:0] dec_mode;
    logic       dec_err;
    logic       full_sel;
    logic       beat_acc;
    logic       last_beat;
    logic       wlast_err;

    axi_wr_dispatch_decode #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) u_decode (
        .awaddr_i  (axi.awaddr),
        .awsize_i  (axi.awsize),
        .awburst_i (axi.awburst),
        .sel_o     (dec_sel),
        .mode_o    (dec_mode),
        .err_o     (dec_err)
    );

    // Compare-based select avoids an index narrower than sel_q when NUM_CH < 16
    always_comb begin
        full_sel = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_q == 4'(c)) full_sel = ch_full_i[c];
        end
    end

    assign axi.awready = (state_q == ST_IDLE);
    assign axi.wready  = ((state_q == ST_DATA) & ~full_sel) | (state_q == ST_DRAIN);
    assign axi.bvalid  = (state_q == ST_RESP);
    assign axi.bid     = axi.bvalid ? id_q : '0;
    assign axi.bresp   = (axi.bvalid & err_q) ? BRESP_SLVERR : BRESP_OKAY;

    assign beat_acc  = axi.wvalid & axi.wready;
    assign last_beat = (cnt_q == 8'd0);

`ifdef AXI_WR_DISPATCH_WLAST_CHECK_EN
    assign wlast_err = beat_acc & (axi.wlast != last_beat);
`else
    logic unused_wlast;
    assign unused_wlast = axi.wlast;
    assign wlast_err    = 1'b0;
`endif

    always_comb begin
        ch_push_o = '0;
        if ((state_q == ST_DATA) && beat_acc) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (sel_q == 4'(c)) ch_push_o[c] = 1'b1;
            end
        end
    end

    assign ch_clr_o   = {NUM_CH{state_q == ST_INIT}};
    assign ch_data_o  = axi.wdata;
    assign ch_strb_o  = axi.wstrb;
    assign ch_index_o = idx_q;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        idx_d   = idx_q;
        case (state_q)
            ST_INIT: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (axi.awvalid) begin
                    id_d    = axi.awid;
                    sel_d   = dec_sel;
                    mode_d  = dec_mode;
                    cnt_d   = axi.awlen;
                    err_d   = dec_err;
                    state_d = dec_err ? ST_DRAIN : ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_acc) begin
                    if (wlast_err) err_d = 1'b1;
                    if (last_beat) begin
                        // index wraps naturally at 2**IDX_W
                        if (mode_q == MODE_LAST) idx_d = idx_q + IDX_W'(1);
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat_acc) begin
                    if (last_beat) state_d = ST_RESP;
                    else           cnt_d   = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (axi.bready) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            id_q    <= '0;
            sel_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_axi_wr_dispatch.sv
// tb_axi_wr_dispatch
//   Self-checking bench for axi_wr_dispatch (NUM_CH=16, DATA_W=32, IDX_W=10).
//   Directed vector table, hand sequences for stall / reset / wlast / index
//   wrap, and randomized bursts against a transaction-level reference model.
module tb_axi_wr_dispatch;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int NUM_CH = 16;
    localparam int IDX_W  = 10;
    localparam int STRB_W = DATA_W / 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_CH-1:0]   ch_full;
    logic [NUM_CH-1:0]   ch_clr;
    logic [NUM_CH-1:0]   ch_push;
    logic [DATA_W-1:0]   ch_data;
    logic [STRB_W-1:0]   ch_strb;
    logic [IDX_W-1:0]    ch_index;

    int errors = 0;
    int checks = 0;
    int push_total = 0;
    logic [IDX_W-1:0] model_idx;

    typedef struct {
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic [ID_W-1:0] id;
        logic            exp_err;
        int              exp_idx_after;
    } vec_t;

    vec_t vecs [8];

    axi_wr_dispatch_if #(.DATA_W(DATA_W), .ID_W(ID_W)) axi ();

    axi_wr_dispatch #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W),
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .axi        (axi),
        .ch_full_i  (ch_full),
        .ch_clr_o   (ch_clr),
        .ch_push_o  (ch_push),
        .ch_data_o  (ch_data),
        .ch_strb_o  (ch_strb),
        .ch_index_o (ch_index)
    );

    always #5 clk = ~clk;

    // Independent count of every push pulse the DUT ever emits
    always @(negedge clk) push_total <= push_total + $countones(ch_push);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decode rules written straight from the address map
    function automatic logic ref_err(input logic [31:0] addr, input logic [2:0] size,
                                     input logic [1:0] burst);
        int sel;
        int mode;
        sel  = int'(addr[7:4]);
        mode = int'(addr[3:0]);
        return (sel >= NUM_CH) || (mode > 1) || (int'(size) != $clog2(STRB_W)) || (burst == 2'b10);
    endfunction

    // One complete burst: AW, W beats, B, then an IDLE check.
    task automatic do_txn(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [ID_W-1:0] id, input logic dec_err,
                          input bit rnd, input int stall_beat, input int stall_cyc,
                          input int bad_wl_beat);
        int k;
        int budget;
        int stalls_left;
        int push0;
        int bdelay;
        logic wl_err;
        logic wlc;
        logic exp_wready;
        logic acc;
        logic exp_err;
        logic [3:0] sel;
        logic last_mode;
        logic [NUM_CH-1:0] exp_push;

        sel         = addr[7:4];
        last_mode   = (addr[3:0] == 4'd1);
        push0       = push_total;
        wl_err      = 1'b0;
        stalls_left = stall_cyc;
`ifdef AXI_WR_DISPATCH_WLAST_CHECK_EN
        wlc = 1'b1;
`else
        wlc = 1'b0;
`endif
        axi.awaddr  = addr;
        axi.awlen   = len;
        axi.awsize  = size;
        axi.awburst = burst;
        axi.awid    = id;
        axi.awvalid = 1'b1;
        @(negedge clk);
        chk("aw_awready", axi.awready, 1);
        chk("aw_wready", axi.wready, 0);
        chk("aw_bvalid", axi.bvalid, 0);
        @(posedge clk); #1;
        axi.awvalid = 1'b0;

        k = 0;
        budget = 0;
        while (k <= int'(len) && budget < 400) begin
            budget++;
            axi.wvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            axi.wdata  = $urandom;
            axi.wstrb  = STRB_W'($urandom);
            axi.wlast  = (k == int'(len)) ^ (k == bad_wl_beat);
            ch_full    = rnd ? (NUM_CH'($urandom) & NUM_CH'($urandom)) : '0;
            if (k == stall_beat && stalls_left > 0) begin
                ch_full[sel] = 1'b1;
                stalls_left--;
            end
            @(negedge clk);
            exp_wready = dec_err ? 1'b1 : ~ch_full[sel];
            chk("wready", axi.wready, exp_wready);
            acc = axi.wvalid & exp_wready;
            exp_push = '0;
            if (acc && !dec_err) exp_push[sel] = 1'b1;
            chk("ch_push", ch_push, exp_push);
            if (acc && !dec_err) begin
                chk("ch_data", ch_data, axi.wdata);
                chk("ch_strb", ch_strb, axi.wstrb);
                chk("ch_index", ch_index, model_idx);
            end
            chk("w_bvalid", axi.bvalid, 0);
            if (acc && (axi.wlast != (k == int'(len)))) wl_err = 1'b1;
            @(posedge clk); #1;
            if (acc) begin
                if (k == int'(len) && !dec_err && last_mode) model_idx = model_idx + 1'b1;
                k++;
            end
        end
        chk("w_beats_done", k, int'(len) + 1);
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        ch_full    = '0;

        exp_err = dec_err | (wlc & wl_err);
        bdelay  = rnd ? $urandom_range(0, 3) : 0;
        for (int i = 0; i <= bdelay; i++) begin
            axi.bready = (i == bdelay);
            @(negedge clk);
            chk("bvalid", axi.bvalid, 1);
            chk("bid", axi.bid, id);
            chk("bresp", axi.bresp, exp_err ? 2'b10 : 2'b00);
            chk("b_push", ch_push, 0);
            @(posedge clk); #1;
        end
        axi.bready = 1'b0;
        chk("push_count", push_total - push0, dec_err ? 0 : int'(len) + 1);
        @(negedge clk);
        chk("idle_awready", axi.awready, 1);
        chk("idle_bvalid", axi.bvalid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          r;
        int          bad;

        reset       = 1'b1;
        axi.awid    = '0;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.awsize  = 3'd2;
        axi.awburst = 2'b01;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wlast   = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        ch_full     = '0;
        model_idx   = '0;

        vecs[0] = '{32'h00, 8'd3, 3'd2, 2'b01, 4'h3, 1'b0, 0};
        vecs[1] = '{32'hF1, 8'd0, 3'd2, 2'b01, 4'h5, 1'b0, 1};
        vecs[2] = '{32'hF1, 8'd0, 3'd2, 2'b01, 4'h6, 1'b0, 2};
        vecs[3] = '{32'h32, 8'd1, 3'd2, 2'b01, 4'h7, 1'b1, 2};
        vecs[4] = '{32'h10, 8'd2, 3'd3, 2'b01, 4'h8, 1'b1, 2};
        vecs[5] = '{32'h20, 8'd1, 3'd2, 2'b10, 4'hA, 1'b1, 2};
        vecs[6] = '{32'h21, 8'd1, 3'd2, 2'b00, 4'hB, 1'b0, 3};
        vecs[7] = '{32'hA0, 8'd5, 3'd2, 2'b01, 4'hC, 1'b0, 3};

        // Reset values, then the INIT clear pulse
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_awready", axi.awready, 0);
        chk("rst_wready", axi.wready, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_bid", axi.bid, 0);
        chk("rst_bresp", axi.bresp, 0);
        chk("rst_push", ch_push, 0);
        chk("rst_index", ch_index, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("init_clr", ch_clr, {NUM_CH{1'b1}});
        chk("init_awready", axi.awready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_clr", ch_clr, 0);
        chk("idle_awready0", axi.awready, 1);
        chk("idle_index0", ch_index, 0);
        @(posedge clk); #1;

        // Directed table
        for (int v = 0; v < 8; v++) begin
            do_txn(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].id,
                   vecs[v].exp_err, 1'b0, -1, 0, -1);
            chk("vec_index_after", ch_index, vecs[v].exp_idx_after);
        end

        // FIFO full on ch0 for 5 cycles in the middle of a 6-beat burst
        do_txn(32'h00, 8'd5, 3'd2, 2'b01, 4'h1, 1'b0, 1'b0, 2, 5, -1);

        // wlast on beat 2 of 4: SLVERR only with the wlast check built in
        do_txn(32'h00, 8'd3, 3'd2, 2'b01, 4'h9, 1'b0, 1'b0, -1, 0, 1);

        // Randomized bursts against the reference model
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            addr = {24'h0, 4'($urandom_range(0, 15)),
                    (r < 5) ? 4'd0 : (r < 9) ? 4'd1 : 4'($urandom_range(2, 15))};
            len  = 8'($urandom_range(0, 7));
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            r = $urandom_range(0, 5);
            burst = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b01;
            bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len)) : -1;
            do_txn(addr, len, size, burst, ID_W'($urandom), ref_err(addr, size, burst),
                   1'b1, -1, 0, bad);
        end

        // Reset in the middle of a burst: no B, INIT pulse follows
        axi.awaddr  = 32'h00;
        axi.awlen   = 8'd7;
        axi.awsize  = 3'd2;
        axi.awburst = 2'b01;
        axi.awid    = 4'h2;
        axi.awvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b1;
        for (int b = 0; b < 2; b++) begin
            axi.wdata = $urandom;
            @(negedge clk);
            chk("mid_push", ch_push, 16'h0001);
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_idx = '0;
        @(negedge clk);
        chk("mid_rst_clr", ch_clr, {NUM_CH{1'b1}});
        chk("mid_rst_bvalid", axi.bvalid, 0);
        chk("mid_rst_wready", axi.wready, 0);
        chk("mid_rst_index", ch_index, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_idle", axi.awready, 1);
        chk("mid_rst_bvalid2", axi.bvalid, 0);
        @(posedge clk); #1;

        // Walk the index up to 1023, then one LAST write wraps it to 0
        while (model_idx != {IDX_W{1'b1}}) begin
            do_txn(32'h01, 8'd0, 3'd2, 2'b01, 4'h0, 1'b0, 1'b0, -1, 0, -1);
        end
        chk("pre_wrap_index", ch_index, 1023);
        do_txn(32'h01, 8'd0, 3'd2, 2'b01, 4'h4, 1'b0, 1'b0, -1, 0, -1);
        chk("wrap_index", ch_index, 0);
        do_txn(32'h11, 8'd1, 3'd2, 2'b01, 4'h4, 1'b0, 1'b0, -1, 0, -1);
        chk("post_wrap_index", ch_index, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
